pattern_controller: RTL and testbench

PATTERN_CONTROLLER -- requirements
Module: pattern_controller

---
 rtl/pattern_controller.sv | 209 ++++++++++++++++++++
 tb/tb_pattern_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_controller.sv
// Display pattern sequencer: frame-synchronous button debounce, manual/auto pattern
// navigation, pause and speed control for downstream VGA pattern generators.
module pattern_controller #(
   parameter int FRAMES_PER_PATTERN = 300,
   parameter int NUM_PATTERNS       = 3,
   parameter int DEBOUNCE_FRAMES    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_pause,
   input  logic       btn_speed,
   input  logic       auto_en,
   output logic [1:0] pattern_sel,
   output logic       paused,
   output logic [2:0] step_size,
   output logic       pattern_rst,
   output logic [9:0] dwell_count
);

   // state       | meaning
   // DB_RELEASED | button idle, waiting for first high frame sample
   // DB_ARMING   | counting consecutive high frame samples
   // DB_HELD     | press reported; waiting for a low sample to re-arm
   typedef enum logic [1:0] {
      DB_RELEASED = 2'd0,
      DB_ARMING   = 2'd1,
      DB_HELD     = 2'd2
   } db_state_t;

   localparam int         NUM_BTNS   = 4;
   localparam int         BTN_NEXT   = 0;
   localparam int         BTN_PREV   = 1;
   localparam int         BTN_PAUSE  = 2;
   localparam int         BTN_SPEED  = 3;
   localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_FRAMES - 1);
   localparam logic [9:0] DWELL_LAST = 10'(FRAMES_PER_PATTERN - 1);
   localparam logic [1:0] SEL_LAST   = 2'(NUM_PATTERNS - 1);

   logic [1:0]          r_vs_sync;
   logic                r_vs_prev;
   logic                w_frame_tick;
   logic [NUM_BTNS-1:0] w_btn_raw;
   logic [NUM_BTNS-1:0] r_btn_meta;
   logic [NUM_BTNS-1:0] r_btn_sync;

   db_state_t           r_db_state     [NUM_BTNS];
   db_state_t           w_db_state_nxt [NUM_BTNS];
   logic [3:0]          r_db_cnt       [NUM_BTNS];
   logic [3:0]          w_db_cnt_nxt   [NUM_BTNS];
   logic [NUM_BTNS-1:0] w_btn_evt;

   logic [1:0] r_pattern_sel;
   logic       r_paused;
   logic [2:0] r_step_size;
   logic       r_pattern_rst;
   logic [9:0] r_dwell_count;
   logic [1:0] w_sel_inc;
   logic [1:0] w_sel_dec;
   logic       w_nav_next;
   logic       w_nav_prev;
   logic       w_counting;
   logic       w_auto_adv;

   // vsync sync chain resets high so an idle-high vsync gives no tick after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vs_sync <= 2'b11;
         r_vs_prev <= 1'b1;
      end else begin
         r_vs_sync <= {r_vs_sync[0], vsync};
         r_vs_prev <= r_vs_sync[1];
      end
   end

   assign w_frame_tick = r_vs_sync[1] & ~r_vs_prev;

   assign w_btn_raw = {btn_speed, btn_pause, btn_prev, btn_next};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn_meta <= '0;
         r_btn_sync <= '0;
      end else begin
         r_btn_meta <= w_btn_raw;
         r_btn_sync <= r_btn_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BTNS; b++) begin
            r_db_state[b] <= DB_RELEASED;
            r_db_cnt[b]   <= 4'd0;
         end
      end else begin
         for (int b = 0; b < NUM_BTNS; b++) begin
            r_db_state[b] <= w_db_state_nxt[b];
            r_db_cnt[b]   <= w_db_cnt_nxt[b];
         end
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BTNS; b++) begin
         w_db_state_nxt[b] = r_db_state[b];
         w_db_cnt_nxt[b]   = r_db_cnt[b];
         if (w_frame_tick) begin
            case (r_db_state[b])
               DB_RELEASED: begin
                  if (r_btn_sync[b]) begin
                     if (DEBOUNCE_FRAMES == 1) begin
                        w_db_state_nxt[b] = DB_HELD;
                        w_db_cnt_nxt[b]   = 4'd0;
                     end else begin
                        w_db_state_nxt[b] = DB_ARMING;
                        w_db_cnt_nxt[b]   = 4'd1;
                     end
                  end
               end
               DB_ARMING: begin
                  if (!r_btn_sync[b]) begin
                     w_db_state_nxt[b] = DB_RELEASED;
                     w_db_cnt_nxt[b]   = 4'd0;
                  end else if (r_db_cnt[b] == DB_LAST) begin
                     w_db_state_nxt[b] = DB_HELD;
                     w_db_cnt_nxt[b]   = 4'd0;
                  end else begin
                     w_db_cnt_nxt[b] = r_db_cnt[b] + 4'd1;
                  end
               end
               DB_HELD: begin
                  if (!r_btn_sync[b]) begin
                     w_db_state_nxt[b] = DB_RELEASED;
                     w_db_cnt_nxt[b]   = 4'd0;
                  end
               end
               default: begin
                  w_db_state_nxt[b] = DB_RELEASED;
                  w_db_cnt_nxt[b]   = 4'd0;
               end
            endcase
         end
      end
   end

   // Press event fires on the frame tick that completes the required high run
   always_comb begin
      w_btn_evt = '0;
      for (int b = 0; b < NUM_BTNS; b++) begin
         if (w_frame_tick && r_btn_sync[b]) begin
            if (r_db_state[b] == DB_ARMING && r_db_cnt[b] == DB_LAST)
               w_btn_evt[b] = 1'b1;
            else if (r_db_state[b] == DB_RELEASED && DEBOUNCE_FRAMES == 1)
               w_btn_evt[b] = 1'b1;
         end
      end
   end

   assign w_sel_inc  = (r_pattern_sel == SEL_LAST) ? 2'd0 : r_pattern_sel + 2'd1;
   assign w_sel_dec  = (r_pattern_sel == 2'd0) ? SEL_LAST : r_pattern_sel - 2'd1;
   assign w_nav_next = w_btn_evt[BTN_NEXT] & ~w_btn_evt[BTN_PREV];
   assign w_nav_prev = w_btn_evt[BTN_PREV] & ~w_btn_evt[BTN_NEXT];
   assign w_counting = w_frame_tick & auto_en & ~r_paused;
   assign w_auto_adv = w_counting & (r_dwell_count == DWELL_LAST);

   // Manual prev outranks a coincident auto-advance; next and auto merge into one step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pattern_sel <= 2'd0;
         r_pattern_rst <= 1'b0;
         r_dwell_count <= 10'd0;
      end else begin
         r_pattern_rst <= 1'b0;
         if (w_nav_prev) begin
            r_pattern_sel <= w_sel_dec;
            r_pattern_rst <= 1'b1;
            r_dwell_count <= 10'd0;
         end else if (w_nav_next || w_auto_adv) begin
            r_pattern_sel <= w_sel_inc;
            r_pattern_rst <= 1'b1;
            r_dwell_count <= 10'd0;
         end else if (w_counting) begin
            r_dwell_count <= r_dwell_count + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_paused    <= 1'b0;
         r_step_size <= 3'd1;
      end else begin
         if (w_btn_evt[BTN_PAUSE])
            r_paused <= ~r_paused;
         if (w_btn_evt[BTN_SPEED])
            r_step_size <= (r_step_size == 3'd7) ? 3'd1 : r_step_size + 3'd1;
      end
   end

   assign pattern_sel = r_pattern_sel;
   assign paused      = r_paused;
   assign step_size   = r_step_size;
   assign pattern_rst = r_pattern_rst;
   assign dwell_count = r_dwell_count;

endmodule

// File: tb/tb_pattern_controller.sv
// Directed bench for pattern_controller: reset, auto-advance, debounce, wraps,
// pause and event collisions, using hand-computed expectations.
module tb_pattern_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vsync = 1'b1;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       btn_pause = 1'b0;
   logic       btn_speed = 1'b0;
   logic       auto_en = 1'b0;
   logic [1:0] pattern_sel;
   logic       paused;
   logic [2:0] step_size;
   logic       pattern_rst;
   logic [9:0] dwell_count;

   int errors = 0;
   int checks = 0;
   int rst_pulses = 0;
   int p0;
   int exp_step [7] = '{2, 3, 4, 5, 6, 7, 1};

   pattern_controller #(
      .FRAMES_PER_PATTERN(300),
      .NUM_PATTERNS(3),
      .DEBOUNCE_FRAMES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vsync(vsync),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .btn_pause(btn_pause),
      .btn_speed(btn_speed),
      .auto_en(auto_en),
      .pattern_sel(pattern_sel),
      .paused(paused),
      .step_size(step_size),
      .pattern_rst(pattern_rst),
      .dwell_count(dwell_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pattern_rst === 1'b1)
         rst_pulses++;
   end

   task automatic do_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) vsync = 1'b0;
         repeat (2) @(negedge clk);
         vsync = 1'b1;
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic set_btns(input logic [3:0] v);
      {btn_speed, btn_pause, btn_prev, btn_next} = v;
   endtask

   task automatic press(input logic [3:0] v);
      set_btns(v);
      do_frames(4);
      set_btns(4'b0000);
      do_frames(1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      set_btns(4'b0000);
      auto_en = 1'b0;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", pattern_sel); end
      checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %0b expected 0", paused); end
      checks++; if (step_size !== 3'd1) begin errors++; $display("FAIL reset_step: got %0d expected 1", step_size); end
      checks++; if (pattern_rst !== 1'b0) begin errors++; $display("FAIL reset_prst: got %0b expected 0", pattern_rst); end
      checks++; if (dwell_count !== 10'd0) begin errors++; $display("FAIL reset_dwell: got %0d expected 0", dwell_count); end
      do_frames(3);
      checks++; if (dwell_count !== 10'd0) begin errors++; $display("FAIL idle_dwell: got %0d expected 0", dwell_count); end
   endtask

   task automatic test_auto_advance();
      apply_reset();
      auto_en = 1'b1;
      p0 = rst_pulses;
      do_frames(299);
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL auto_sel299: got %0d expected 0", pattern_sel); end
      checks++; if (dwell_count !== 10'd299) begin errors++; $display("FAIL auto_dwell299: got %0d expected 299", dwell_count); end
      do_frames(1);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL auto_sel300: got %0d expected 1", pattern_sel); end
      checks++; if (dwell_count !== 10'd0) begin errors++; $display("FAIL auto_dwell300: got %0d expected 0", dwell_count); end
      checks++; if (rst_pulses - p0 !== 1) begin errors++; $display("FAIL auto_pulses300: got %0d expected 1", rst_pulses - p0); end
      do_frames(600);
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL auto_sel900: got %0d expected 0", pattern_sel); end
      checks++; if (rst_pulses - p0 !== 3) begin errors++; $display("FAIL auto_pulses900: got %0d expected 3", rst_pulses - p0); end
      auto_en = 1'b0;
   endtask

   task automatic test_debounce();
      apply_reset();
      p0 = rst_pulses;
      set_btns(4'b0001);
      do_frames(3);
      set_btns(4'b0000);
      do_frames(1);
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL db_short: got %0d expected 0", pattern_sel); end
      set_btns(4'b0001);
      do_frames(4);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL db_press: got %0d expected 1", pattern_sel); end
      checks++; if (rst_pulses - p0 !== 1) begin errors++; $display("FAIL db_press_pulse: got %0d expected 1", rst_pulses - p0); end
      do_frames(50);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL db_hold: got %0d expected 1", pattern_sel); end
      checks++; if (rst_pulses - p0 !== 1) begin errors++; $display("FAIL db_hold_pulse: got %0d expected 1", rst_pulses - p0); end
      set_btns(4'b0000);
      do_frames(1);
      // reset mid-press: held button must re-qualify for the full count
      set_btns(4'b0001);
      do_frames(3);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_frames(3);
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL db_rst_abort: got %0d expected 0", pattern_sel); end
      do_frames(1);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL db_rst_full: got %0d expected 1", pattern_sel); end
      set_btns(4'b0000);
      do_frames(1);
   endtask

   task automatic test_prev_wrap();
      apply_reset();
      auto_en = 1'b1;
      do_frames(10);
      auto_en = 1'b0;
      do_frames(3);
      checks++; if (dwell_count !== 10'd10) begin errors++; $display("FAIL prev_dwell_hold: got %0d expected 10", dwell_count); end
      p0 = rst_pulses;
      press(4'b0010);
      checks++; if (pattern_sel !== 2'd2) begin errors++; $display("FAIL prev_wrap_sel: got %0d expected 2", pattern_sel); end
      checks++; if (dwell_count !== 10'd0) begin errors++; $display("FAIL prev_wrap_dwell: got %0d expected 0", dwell_count); end
      checks++; if (rst_pulses - p0 !== 1) begin errors++; $display("FAIL prev_wrap_pulse: got %0d expected 1", rst_pulses - p0); end
      press(4'b0010);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL prev_step_sel: got %0d expected 1", pattern_sel); end
   endtask

   task automatic test_speed_wrap();
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         press(4'b1000);
         checks++;
         if (step_size !== 3'(exp_step[i])) begin
            errors++;
            $display("FAIL speed_press%0d: got %0d expected %0d", i + 1, step_size, exp_step[i]);
         end
      end
   endtask

   task automatic test_pause();
      apply_reset();
      auto_en = 1'b1;
      do_frames(96);
      press(4'b0100);
      checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_set: got %0b expected 1", paused); end
      checks++; if (dwell_count !== 10'd100) begin errors++; $display("FAIL pause_dwell0: got %0d expected 100", dwell_count); end
      do_frames(500);
      checks++; if (dwell_count !== 10'd100) begin errors++; $display("FAIL pause_dwell500: got %0d expected 100", dwell_count); end
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL pause_sel: got %0d expected 0", pattern_sel); end
      p0 = rst_pulses;
      press(4'b0001);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL pause_next_sel: got %0d expected 1", pattern_sel); end
      checks++; if (dwell_count !== 10'd0) begin errors++; $display("FAIL pause_next_dwell: got %0d expected 0", dwell_count); end
      checks++; if (rst_pulses - p0 !== 1) begin errors++; $display("FAIL pause_next_pulse: got %0d expected 1", rst_pulses - p0); end
      checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_kept: got %0b expected 1", paused); end
      auto_en = 1'b0;
   endtask

   task automatic test_collisions();
      apply_reset();
      p0 = rst_pulses;
      press(4'b0011);
      checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL coll_np_sel: got %0d expected 0", pattern_sel); end
      checks++; if (rst_pulses - p0 !== 0) begin errors++; $display("FAIL coll_np_pulse: got %0d expected 0", rst_pulses - p0); end
      apply_reset();
      auto_en = 1'b1;
      do_frames(296);
      checks++; if (dwell_count !== 10'd296) begin errors++; $display("FAIL coll_auto_pre: got %0d expected 296", dwell_count); end
      p0 = rst_pulses;
      set_btns(4'b0001);
      do_frames(4);
      checks++; if (pattern_sel !== 2'd1) begin errors++; $display("FAIL coll_auto_sel: got %0d expected 1", pattern_sel); end
      checks++; if (dwell_count !== 10'd0) begin errors++; $display("FAIL coll_auto_dwell: got %0d expected 0", dwell_count); end
      checks++; if (rst_pulses - p0 !== 1) begin errors++; $display("FAIL coll_auto_pulse: got %0d expected 1", rst_pulses - p0); end
      set_btns(4'b0000);
      auto_en = 1'b0;
      do_frames(1);
   endtask

   initial begin
      test_reset();
      test_auto_advance();
      test_debounce();
      test_prev_wrap();
      test_speed_wrap();
      test_pause();
      test_collisions();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
